uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
Boot-time writer for the instruction memory read by the fetch stage. Receives a program image over a UART RX line (8N1, LSB first), assembles little-endian 32-bit words and issues one write per word into instruction memory. After the last word is written it raises enable_pc, releasing the PC register to start fetching from address 0.

Parameters:
width, 32, data/address width; equals instruction word width
depth, 1024, instruction memory depth in words
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal values >= 4, even

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
rx  input  1  UART serial input, idle high, asynchronous to clk
imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
imem_addr  output  width  byte address of the word being written, always word-aligned
imem_wdata  output  width  word being written
enable_pc  output  1  high once load completes; sticky until reset
busy  output  1  high from first start bit accepted until enable_pc rises
frame_err  output  1  sticky; set on any stop bit sampled low
overflow  output  1  sticky; set when the header word count exceeds depth

Behaviour:
- Reset (reset low, async): every output 0; both FSMs to idle; counters 0; rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser; all sampling below uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge (sync rx 1->0) -> START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 cycles, sample. Low -> DATA. High -> IDLE (glitch rejected, no byte).
  - DATA: sample every CLKS_PER_BIT cycles; 8 samples shifted in LSB first -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. High -> internal byte_valid pulse for 1 cycle, then IDLE. Low -> byte discarded, frame_err set, then IDLE. A new start is detected only once rx has returned high.
- Loader FSM states: HDR, LOAD, DONE.
  - HDR: collects 4 bytes little-endian into word count N (byte 0 = bits 7:0).
    - N==0 -> DONE.
    - N>depth -> overflow set; proceed to LOAD with N unchanged; writes at word index >= depth are suppressed (imem_we stays 0) but their bytes are still consumed.
  - LOAD: byte lane counter 0..3 assembles word little-endian. The cycle after the 4th byte's byte_valid:
    - imem_we=1 for exactly 1 cycle;
    - imem_addr = word_index*4;
    - imem_wdata = assembled word;
    - word_index increments.
    - After word N-1 is written -> DONE.
  - DONE: enable_pc=1 the cycle after the last imem_we (or after the 4th header byte when N==0). All further rx traffic is ignored, and frame_err does not update in DONE.
- imem_addr and imem_wdata hold their last values between strobes. Only imem_we qualifies them.
- busy: set on the cycle START confirms the first start bit; cleared on the cycle enable_pc rises.
- A framed-bad byte is not counted: lane and word counters do not advance.
- reset asserted mid-load aborts immediately. Partial words are never written. enable_pc returns to 0. After release, a full header is required again.

Test Plan:
- CLKS_PER_BIT=4: send header 02 00 00 00, then 13 00 00 00, 93 00 10 00 -> imem_we pulses twice: (addr 0x0, data 0x00000013), then (addr 0x4, data 0x00100093); enable_pc rises 1 cycle after the 2nd pulse; busy high in between; frame_err=0.
- Header 00 00 00 00 -> no imem_we; enable_pc=1 one cycle after the 4th header byte.
- 1-cycle and 2-cycle low glitches on idle rx, then valid 1-word load of 0xDEADBEEF -> glitches produce no byte; single write (0x0, 0xDEADBEEF).
- Header N=1, then byte with stop bit forced low, then 4 good bytes EF BE AD DE -> frame_err=1; bad byte not counted; single write 0xDEADBEEF at 0x0; enable_pc=1.
- depth=4, header N=5, 5 words -> overflow=1; 4 writes at 0x0..0xC; 5th word consumed with no imem_we; enable_pc=1 after the 5th word's last byte.
- Reset pulsed low after 2 bytes of word 1 (N=3) -> all outputs 0 immediately; then a fresh header with N=1 and one word loads correctly to addr 0x0.

Source files
------------

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed program image over UART 8N1 and writes it
// word by word into instruction memory, then releases the PC.
module uart_imem_loader #(
    parameter int width        = 32,
    parameter int depth        = 1024,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic             imem_we,
    output logic [width-1:0] imem_addr,
    output logic [width-1:0] imem_wdata,
    output logic             enable_pc,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [width-1:0] DEPTH_W = width'(depth);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [1:0] {LD_HDR, LD_LOAD, LD_DONE} ldState_t;

    rxState_t         rxState_q, rxState_d;
    ldState_t         ldState_q, ldState_d;
    logic             rxMeta_q, rxSync_q, rxPrev_q;
    logic [CW-1:0]    clkCnt_q, clkCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       lane_q, lane_d;
    logic [width-1:0] word_q, word_d, accWord;
    logic [width-1:0] count_q, count_d;
    logic [width-1:0] wordIdx_q, wordIdx_d;
    logic [width-1:0] addr_d, wdata_d;
    logic             we_d, enable_d, busy_d, ferr_d, ovf_d;
    logic             byteValid, startOk, stopBad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            rxPrev_q   <= 1'b1;
            rxState_q  <= RX_IDLE;
            ldState_q  <= LD_HDR;
            clkCnt_q   <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            count_q    <= '0;
            wordIdx_q  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            enable_pc  <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rxMeta_q   <= rx;
            rxSync_q   <= rxMeta_q;
            rxPrev_q   <= rxSync_q;
            rxState_q  <= rxState_d;
            ldState_q  <= ldState_d;
            clkCnt_q   <= clkCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            count_q    <= count_d;
            wordIdx_q  <= wordIdx_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            enable_pc  <= enable_d;
            busy       <= busy_d;
            frame_err  <= ferr_d;
            overflow   <= ovf_d;
        end
    end

    // Edge-triggered start detection keeps a low stop bit from re-arming the receiver.
    always_comb begin
        rxState_d = rxState_q;
        clkCnt_d  = clkCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        byteValid = 1'b0;
        startOk   = 1'b0;
        stopBad   = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (rxPrev_q && !rxSync_q) begin
                    rxState_d = RX_START;
                    clkCnt_d  = '0;
                    bitCnt_d  = '0;
                end
            end
            RX_START: begin
                if (clkCnt_q == HALF_M1) begin
                    clkCnt_d = '0;
                    if (!rxSync_q) begin
                        startOk   = 1'b1;
                        rxState_d = RX_DATA;
                    end else begin
                        rxState_d = RX_IDLE;
                    end
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clkCnt_q == FULL_M1) begin
                    clkCnt_d = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'd7) rxState_d = RX_STOP;
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clkCnt_q == FULL_M1) begin
                    clkCnt_d  = '0;
                    rxState_d = RX_IDLE;
                    if (rxSync_q) byteValid = 1'b1;
                    else          stopBad   = 1'b1;
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ldState_d = ldState_q;
        lane_d    = lane_q;
        word_d    = word_q;
        count_d   = count_q;
        wordIdx_d = wordIdx_q;
        we_d      = 1'b0;
        addr_d    = imem_addr;
        wdata_d   = imem_wdata;
        ovf_d     = overflow;
        enable_d  = enable_pc | (ldState_q == LD_DONE);
        busy_d    = (ldState_q == LD_DONE) ? 1'b0 : (busy | startOk);
        ferr_d    = frame_err | (stopBad && (ldState_q != LD_DONE));
        accWord   = word_q;
        accWord[{lane_q, 3'b000} +: 8] = shift_q;

        if (byteValid && (ldState_q != LD_DONE)) begin
            word_d = accWord;
            lane_d = lane_q + 1'b1;
            if (lane_q == 2'd3) begin
                if (ldState_q == LD_HDR) begin
                    count_d   = accWord;
                    wordIdx_d = '0;
                    if (accWord == '0) begin
                        ldState_d = LD_DONE;
                    end else begin
                        ldState_d = LD_LOAD;
                        if (accWord > DEPTH_W) ovf_d = 1'b1;
                    end
                end else begin
                    // Words past the memory end are consumed so the stream stays aligned.
                    if (wordIdx_q < DEPTH_W) begin
                        we_d    = 1'b1;
                        addr_d  = {wordIdx_q[width-3:0], 2'b00};
                        wdata_d = accWord;
                    end
                    wordIdx_d = wordIdx_q + 1'b1;
                    if (wordIdx_q == count_q - 1'b1) ldState_d = LD_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized scoreboard bench for uart_imem_loader: a byte-level model predicts the
// memory writes and status flags of each boot image sent over the serial line.
module tb_uart_imem_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        enable_pc;
    logic        busy;
    logic        frame_err;
    logic        overflow;

    int   total = 0;
    int   bad   = 0;
    wr_t  expQ[$];
    logic [7:0] txQ[$];
    bit   txBad[$];
    bit   expEnAfterWe;
    bit   prevEn, prevWe;
    wr_t  mon;

    uart_imem_loader #(.width(32), .depth(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .enable_pc  (enable_pc),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every write strobe is matched against the oldest predicted write.
    initial begin
        prevEn = 1'b0;
        prevWe = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (imem_we) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_we", {32'h0, imem_addr}, 64'hFFFF_FFFF);
                    end else begin
                        mon = expQ.pop_front();
                        checkOutput("we_addr", {32'h0, imem_addr}, {32'h0, mon.addr});
                        checkOutput("we_data", {32'h0, imem_wdata}, {32'h0, mon.data});
                    end
                    checkOutput("busy_during_we", {63'h0, busy}, 64'h1);
                end
                if (enable_pc && !prevEn) begin
                    if (expEnAfterWe) checkOutput("en_after_last_we", {63'h0, prevWe}, 64'h1);
                    checkOutput("busy_clear_on_en", {63'h0, busy}, 64'h0);
                end
                prevEn = enable_pc;
                prevWe = imem_we;
            end else begin
                prevEn = 1'b0;
                prevWe = 1'b0;
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit badStop);
        logic [9:0] frame;
        frame = {~badStop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB * $urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic queueByte(input logic [7:0] b, input bit badStop);
        txQ.push_back(b);
        txBad.push_back(badStop);
    endtask

    task automatic queueHeader(input logic [31:0] n);
        for (int i = 0; i < 4; i++) queueByte(n[8*i +: 8], 1'b0);
    endtask

    // Reference: word i lands at byte address 4*i, unless it falls beyond the memory.
    task automatic queueWord(input int idx, input logic [31:0] d);
        wr_t e;
        for (int i = 0; i < 4; i++) queueByte(d[8*i +: 8], 1'b0);
        if (idx < DEPTH) begin
            e.addr = 32'(idx * 4);
            e.data = d;
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input string tag);
        for (int i = 0; i < txQ.size(); i++) begin
            if (i == txQ.size() - 1) checkOutput({tag, "_en_early"}, {63'h0, enable_pc}, 64'h0);
            sendByte(txQ[i], txBad[i]);
        end
        txQ.delete();
        txBad.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        checkOutput("reset_outputs",
                    {31'h0, imem_we, imem_addr},
                    64'h0);
        checkOutput("reset_flags",
                    {28'h0, enable_pc, busy, frame_err, overflow, imem_wdata},
                    64'h0);
        expQ.delete();
        txQ.delete();
        txBad.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic runLoad(input logic [31:0] n, input bit expF, input string tag);
        expEnAfterWe = (n != 0) && (n <= DEPTH);
        applyStimulus(tag);
        checkOutput({tag, "_enable"},   {63'h0, enable_pc}, 64'h1);
        checkOutput({tag, "_busy"},     {63'h0, busy}, 64'h0);
        checkOutput({tag, "_frame"},    {63'h0, frame_err}, {63'h0, expF});
        checkOutput({tag, "_overflow"}, {63'h0, overflow}, {63'h0, (n > DEPTH)});
        checkOutput({tag, "_missing"},  64'(expQ.size()), 64'h0);
        // Traffic after completion, including a bad frame, must be ignored.
        sendByte(8'($urandom), 1'b1);
        checkOutput({tag, "_done_frame"}, {63'h0, frame_err}, {63'h0, expF});
        checkOutput({tag, "_done_en"},    {63'h0, enable_pc}, 64'h1);
    endtask

    task automatic randomLoad(input int r);
        int n;
        int pos;
        bit fe;
        n  = $urandom_range(0, 6);
        fe = 1'($urandom_range(0, 1));
        queueHeader(32'(n));
        for (int w = 0; w < n; w++) queueWord(w, $urandom);
        if (fe) begin
            pos = $urandom_range(0, txQ.size() - 1);
            txQ.insert(pos, 8'($urandom));
            txBad.insert(pos, 1'b1);
        end
        runLoad(32'(n), fe, $sformatf("rnd%0d", r));
        doReset();
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b0;
        expEnAfterWe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        doReset();

        queueHeader(32'd2);
        queueWord(0, 32'h0000_0013);
        queueWord(1, 32'h0010_0093);
        runLoad(32'd2, 1'b0, "two_words");
        doReset();

        queueHeader(32'd0);
        runLoad(32'd0, 1'b0, "empty");
        doReset();

        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("glitch_busy", {63'h0, busy}, 64'h0);
        queueHeader(32'd1);
        queueWord(0, 32'hDEAD_BEEF);
        runLoad(32'd1, 1'b0, "glitch");
        doReset();

        queueHeader(32'd1);
        queueByte(8'h5A, 1'b1);
        queueWord(0, 32'hDEAD_BEEF);
        runLoad(32'd1, 1'b1, "badstop");
        doReset();

        queueHeader(32'd5);
        for (int w = 0; w < 5; w++) queueWord(w, $urandom);
        runLoad(32'd5, 1'b0, "overflow");
        doReset();

        queueHeader(32'd3);
        queueWord(0, 32'h1234_5678);
        for (int i = 0; i < 6; i++) sendByte(txQ[i], 1'b0);
        checkOutput("abort_busy", {63'h0, busy}, 64'h1);
        doReset();
        queueHeader(32'd1);
        queueWord(0, 32'hCAFE_F00D);
        runLoad(32'd1, 1'b0, "after_abort");
        doReset();

        for (int r = 0; r < 6; r++) randomLoad(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
